// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one result bit per clock, LSB first.
// A single 1-bit full adder is reused every cycle. A carry register holds
// the carry between cycles.
// Optional macro SERIAL_ADDER_SUB_EN adds a `sub` input for a-b.
// Without that macro the block always computes a+b.
// Handshake: a `start` seen in IDLE or DONE loads the operands. `start`
// is ignored while busy. `done` pulses for one cycle when sum, carry_out
// and overflow update. These outputs hold until the next completion.

module adder_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    // One extra bit so the counter can reach WIDTH without wrapping.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-2:0] r_acc;     // result bits produced so far, top-aligned
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_load;
    logic             w_last;
    logic             w_sub;
    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_acc_next;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    // Operands are accepted from IDLE and from DONE, which allows back-to-back operations.
    assign w_load = start && (r_state != RUN);
    assign w_last = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));

    adder_bit u_bit (
        .i_a (r_a[0]),
        .i_b (r_b[0]),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_c)
    );

    // The new bit enters at the MSB. After WIDTH shifts, the word is aligned.
    assign w_acc_next = {w_s, r_acc};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = start ? RUN : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: load on accept, shift one bit per RUN cycle, publish on the last bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_load) begin
            // Subtraction is a + ~b + 1. The +1 is the initial carry.
            r_a     <= a;
            r_b     <= w_sub ? ~b : b;
            r_carry <= w_sub;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_c;
            r_acc   <= w_acc_next[WIDTH-1:1];
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                // On the MSB cycle, r_carry holds the carry into the MSB.
                r_sum  <= w_acc_next;
                r_cout <= w_c;
                r_ovf  <= r_carry ^ w_c;
            end
        end
    end

    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);
    assign sum       = r_sum;
    assign carry_out = r_cout;
    assign overflow  = r_ovf;

endmodule
